// File: rtl/pc_fetch_ctrl.sv
// Program-counter sequencer and instruction-fetch port for the IF stage.
// Issues fetch requests, applies branch/jump redirects and holds one
// fetched instruction toward IF/ID while honouring downstream stall.
module pc_fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              mem_ack,
   input  logic [INST_W-1:0] mem_rdata,
   output logic              mem_ce,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst,
   output logic              stallreq,
   output logic              fetch_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ERR   = 2'd2
   } state_t;

   // Wait counter is 8 bits wide so any limit in 1..255 fits.
   localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

   state_t            state_q;
   logic [7:0]        wait_cnt_q;
   logic              fetch_err_q;

   logic [ADDR_W-1:0] pc_q,       pc_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q,    if_pc_d;
   logic [INST_W-1:0] if_inst_q,  if_inst_d;

   logic              ack_take;
   logic              fetch_miss;

   // A request is only raised while fetching, when the buffer has room
   // (empty or draining this cycle) and no redirect is overriding it.
   assign mem_ce     = (state_q == ST_FETCH) & (~if_valid_q | ~stall_in) & ~br_valid;
   assign ack_take   = mem_ce & mem_ack;
   assign fetch_miss = mem_ce & ~mem_ack;

   assign mem_addr  = pc_q;
   assign pc        = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;
   assign stallreq  = fetch_miss;
   assign fetch_err = fetch_err_q;

   // Next pc and IF/ID buffer: redirect first, then drain, then refill on ack.
   always_comb begin
      pc_d       = pc_q;
      if_valid_d = if_valid_q;
      if_pc_d    = if_pc_q;
      if_inst_d  = if_inst_q;
      if (br_valid) begin
         pc_d       = {br_target[ADDR_W-1:2], 2'b00};
         if_valid_d = 1'b0;
      end else begin
         if (if_valid_q && !stall_in) begin
            if_valid_d = 1'b0;
         end
         if (ack_take) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = mem_rdata;
            pc_d       = pc_q + ADDR_W'(4);
         end
      end
   end

   // Datapath registers: pc and the single-entry instruction buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   // Control FSM with the unacked-request watchdog and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wait_cnt_q  <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_FETCH;
            end
            ST_FETCH: begin
               if (fetch_miss && (wait_cnt_q == WAIT_LIMIT)) begin
                  state_q     <= ST_ERR;
                  fetch_err_q <= 1'b1;
               end
            end
            ST_ERR: begin
               state_q <= ST_ERR;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         // Count consecutive unacked request cycles; any gap or ack restarts it.
         if (br_valid || !fetch_miss) begin
            wait_cnt_q <= '0;
         end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a cycle-level reference model.
module tb_pc_fetch_ctrl;

   localparam int WAIT_MAX = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        mem_ce;
   logic [31:0] mem_addr;
   logic [31:0] pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq;
   logic        fetch_err;

   // Memory emulation: zero-wait mode acks every request, otherwise ack is forced.
   logic zw = 1'b1;
   logic ack_force = 1'b0;
   logic chk_en = 1'b0;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0BAD_0000;
   endfunction

   assign mem_ack   = zw ? mem_ce : ack_force;
   assign mem_rdata = inst_of(mem_addr);

   pc_fetch_ctrl #(
      .ADDR_W   (32),
      .INST_W   (32),
      .RESET_PC (32'h0000_0000),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stall_in  (stall_in),
      .br_valid  (br_valid),
      .br_target (br_target),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .mem_ce    (mem_ce),
      .mem_addr  (mem_addr),
      .pc        (pc),
      .if_valid  (if_valid),
      .if_pc     (if_pc),
      .if_inst   (if_inst),
      .stallreq  (stallreq),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Abstract view: "started" means the first edge after reset has passed,
   // "err" means the watchdog fired, misses counts unacked request cycles.
   logic        m_started, m_err, m_bv;
   logic [31:0] m_pc, m_bpc, m_binst;
   int          m_misses;

   wire m_ce = m_started && !m_err && (!m_bv || !stall_in) && !br_valid;

   logic        s_ce, s_ack, s_br, s_stall;
   logic [31:0] s_tgt, s_rdata;

   // Compare every cycle, then capture the inputs the next edge will act on.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_mem_ce",    {31'd0, mem_ce},    {31'd0, m_ce});
         chk("model_mem_addr",  mem_addr,           m_pc);
         chk("model_pc",        pc,                 m_pc);
         chk("model_if_valid",  {31'd0, if_valid},  {31'd0, m_bv});
         chk("model_if_pc",     if_pc,              m_bpc);
         chk("model_if_inst",   if_inst,            m_binst);
         chk("model_stallreq",  {31'd0, stallreq},  {31'd0, m_ce && !mem_ack});
         chk("model_fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      end
      s_ce    <= m_ce;
      s_ack   <= mem_ack;
      s_br    <= br_valid;
      s_stall <= stall_in;
      s_tgt   <= br_target;
      s_rdata <= mem_rdata;
   end

   // Advance the model by one clock edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_started <= 1'b0;
         m_err     <= 1'b0;
         m_bv      <= 1'b0;
         m_pc      <= 32'h0;
         m_bpc     <= 32'h0;
         m_binst   <= 32'h0;
         m_misses  <= 0;
      end else begin
         m_started <= 1'b1;
         if (s_br) begin
            m_pc     <= s_tgt & 32'hFFFF_FFFC;
            m_bv     <= 1'b0;
            m_misses <= 0;
         end else if (s_ce && s_ack) begin
            m_bv     <= 1'b1;
            m_bpc    <= m_pc;
            m_binst  <= s_rdata;
            m_pc     <= m_pc + 32'd4;
            m_misses <= 0;
         end else begin
            if (m_bv && !s_stall) m_bv <= 1'b0;
            if (s_ce) begin
               if (m_misses == WAIT_MAX) m_err <= 1'b1;
               m_misses <= m_misses + 1;
            end else begin
               m_misses <= 0;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   initial begin
      next();
      next();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_mem_ce",    {31'd0, mem_ce},    32'd0);
      chk("rst_pc",        pc,                 32'h0);
      chk("rst_if_valid",  {31'd0, if_valid},  32'd0);
      chk("rst_stallreq",  {31'd0, stallreq},  32'd0);
      chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

      // T1: zero-wait fetch stream after reset release
      next(); rst = 1'b0;
      @(negedge clk); chk("t1_idle_ce", {31'd0, mem_ce}, 32'd0);
      next(); @(negedge clk); chk("t1_addr0", mem_addr, 32'h0); chk("t1_ce", {31'd0, mem_ce}, 32'd1);
      next(); @(negedge clk); chk("t1_addr4", mem_addr, 32'h4); chk("t1_ifpc0", if_pc, 32'h0);
      next(); @(negedge clk); chk("t1_addr8", mem_addr, 32'h8); chk("t1_ifpc4", if_pc, 32'h4);

      // T2: hold the buffered instruction at 8 for three cycles
      next(); stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_ce", {31'd0, mem_ce}, 32'd0);
         chk("t2_ifpc", if_pc, 32'h8);
         chk("t2_pc", pc, 32'hC);
         next();
      end
      stall_in = 1'b0;
      @(negedge clk); chk("t2_resume_addr", mem_addr, 32'hC); chk("t2_resume_ce", {31'd0, mem_ce}, 32'd1);

      // T3: redirect during a waited fetch of 0x10, stale ack in redirect cycle
      next(); zw = 1'b0; ack_force = 1'b0;
      @(negedge clk); chk("t3_addr10", mem_addr, 32'h10); chk("t3_stallreq", {31'd0, stallreq}, 32'd1);
      next();
      @(negedge clk); chk("t3_drained", {31'd0, if_valid}, 32'd0);
      next(); br_valid = 1'b1; br_target = 32'h103; ack_force = 1'b1;
      @(negedge clk); chk("t3_br_ce", {31'd0, mem_ce}, 32'd0);
      next(); br_valid = 1'b0; ack_force = 1'b0;
      @(negedge clk); chk("t3_addr100", mem_addr, 32'h100); chk("t3_ifv", {31'd0, if_valid}, 32'd0);
      next(); zw = 1'b1;
      @(negedge clk); chk("t3_ce100", {31'd0, mem_ce}, 32'd1);

      // T4: redirect, stall and ack all together
      next(); br_valid = 1'b1; br_target = 32'h200; stall_in = 1'b1; zw = 1'b0; ack_force = 1'b1;
      @(negedge clk);
      chk("t3_ifpc", if_pc, 32'h100);
      chk("t3_ifinst", if_inst, inst_of(32'h100));
      next(); br_valid = 1'b0; stall_in = 1'b0; ack_force = 1'b0; zw = 1'b1;
      @(negedge clk); chk("t4_ifv", {31'd0, if_valid}, 32'd0); chk("t4_pc", pc, 32'h200);

      // T6: pc wraps modulo 2^32
      next(); br_valid = 1'b1; br_target = 32'hFFFF_FFFC;
      next(); br_valid = 1'b0;
      @(negedge clk); chk("t6_addr_top", mem_addr, 32'hFFFF_FFFC);
      next();
      @(negedge clk); chk("t6_addr_wrap", mem_addr, 32'h0); chk("t6_ifpc", if_pc, 32'hFFFF_FFFC);

      // T5: watchdog with the memory never acking
      next(); zw = 1'b0; ack_force = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("t5_stallreq", {31'd0, stallreq}, 32'd1);
         next();
      end
      zw = 1'b1;
      @(negedge clk); chk("t5_err", {31'd0, fetch_err}, 32'd1); chk("t5_ce", {31'd0, mem_ce}, 32'd0);
      repeat (3) begin
         next();
         @(negedge clk); chk("t5_err_sticky", {31'd0, fetch_err}, 32'd1); chk("t5_ifv", {31'd0, if_valid}, 32'd0);
      end

      // Async reset clears the error; redirect while idle sets the first fetch
      next(); #2 rst = 1'b1;
      @(negedge clk); chk("rst2_err", {31'd0, fetch_err}, 32'd0); chk("rst2_pc", pc, 32'h0);
      next(); rst = 1'b0; br_valid = 1'b1; br_target = 32'h41;
      @(negedge clk); chk("idle_br_ce", {31'd0, mem_ce}, 32'd0);
      next(); br_valid = 1'b0;
      @(negedge clk); chk("idle_br_addr", mem_addr, 32'h40);
      next();
      @(negedge clk); chk("idle_br_ifpc", if_pc, 32'h40);

      // Reset in the middle of an outstanding fetch; its ack is ignored
      next(); zw = 1'b0; ack_force = 1'b0;
      next(); #2 rst = 1'b1; ack_force = 1'b1;
      @(negedge clk); chk("rst3_ifv", {31'd0, if_valid}, 32'd0); chk("rst3_ce", {31'd0, mem_ce}, 32'd0);
      next(); rst = 1'b0; ack_force = 1'b0; zw = 1'b1;
      next();
      @(negedge clk); chk("rst3_addr0", mem_addr, 32'h0);
      next();
      @(negedge clk); chk("rst3_ifinst", if_inst, inst_of(32'h0));

      next();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Hard time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout t=%0t got=running expected=finished", $time);
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
